// File: rtl/seq_shifter.sv
// seq_shifter: iterative 16-bit shifter that moves the operand one bit per clock.
// It supports SLL, SRA, ROR and ROL, with a start/busy/done handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; Shift_Out holds the last result
//   S_SHIFT | one single-bit step per cycle until the count reaches zero
//   S_DONE  | done pulse for one cycle; start is ignored here
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [CNT_W-1:0] Shift_Val,
    input  logic [1:0]       Mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Shift_Out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_shift_out;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] w_step;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);
    assign Shift_Out  = r_shift_out;

    // State register; a reset also aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; DONE always returns to IDLE so start is never taken there
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_cnt_zero) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded directly from state
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Single-bit step selected by the latched mode
    always_comb begin
        w_step = r_data;
        case (r_mode)
            MODE_SLL: w_step = {r_data[WIDTH-2:0], 1'b0};
            MODE_SRA: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            MODE_ROR: w_step = {r_data[0], r_data[WIDTH-1:1]};
            default:  w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        endcase
    end

    // Datapath: latch operands on an accepted start, step with a down-count,
    // and publish the result only when the count runs out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_cnt       <= '0;
            r_mode      <= '0;
            r_shift_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data <= Shift_In;
                        r_cnt  <= Shift_Val;
                        r_mode <= Mode;
                    end
                end
                S_SHIFT: begin
                    if (w_cnt_zero) begin
                        r_shift_out <= r_data;
                    end else begin
                        r_data <= w_step;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle iterative shifter for the 16-bit datapath. It accepts an operand, a shift amount and a mode through a start/done handshake, then shifts one bit position per clock.
- Supports SLL, SRA, ROR and ROL. ROL is the inverse direction of ROR, so rotates can be undone.
- Used where a single-cycle barrel shifter is too costly. It also gives the single-cycle shifter bench a golden, bit-serial counterpart.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 4, width of the shift-amount field; maximum shift is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- Shift_In  input  WIDTH  operand; sampled on the accepted start.
- Shift_Val  input  CNT_W  shift amount; sampled on the accepted start.
- Mode  input  2  operation select: 00 SLL, 01 SRA, 10 ROR, 11 ROL.
- busy  output  1  high in SHIFT and DONE; start is ignored while high.
- done  output  1  one-cycle pulse when Shift_Out holds the final result.
- Shift_Out  output  WIDTH  result register.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: rst_n=0 at a rising edge forces the following:
  - state=IDLE;
  - Shift_Out=0, done=0, busy=0;
  - internal count=0, internal mode=00.
- Reset mid-operation aborts the operation: no done pulse, and Shift_Out clears to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, load data_reg<=Shift_In, cnt<=Shift_Val, mode_reg<=Mode, then go to SHIFT.
  - On start=0, hold state. Shift_Out keeps its last result.
- SHIFT, when cnt!=0: apply one single-bit step to data_reg and decrement cnt.
  - SLL: {d[W-2:0],1'b0}
  - SRA: {d[W-1],d[W-1:1]}
  - ROR: {d[0],d[W-1:1]}
  - ROL: {d[W-2:0],d[W-1]}
- SHIFT, when cnt==0: Shift_Out<=data_reg, go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
  - start asserted during DONE is ignored.
  - start is first accepted in the IDLE cycle that follows.
- Latency: start high in cycle 0 means done is high in cycle Shift_Val+2.
  - Shift_Val=0 gives done in cycle 2, with Shift_Out==Shift_In.
  - Shift_Val=15 gives done in cycle 17.
- Back-to-back throughput: one operation per Shift_Val+3 cycles.
- Shift_Out updates only on the SHIFT->DONE transition. It is stable from done until the next operation completes, including across new starts.
- Inputs may change freely after an accepted start; the block uses only the latched copies.
- busy = (state!=IDLE). busy rises in the cycle after the accepted start.
- No arithmetic overflow flag.
- SRA of a negative operand by 15 yields all ones.
- SLL/SRA/ROR results match Shift_In<<n, Shift_In>>>n (signed), and {In[n-1:0],In[W-1:n]} respectively.
- ROL result is {In[W-1-n:0],In[W-1:W-n]}.

Test Plan:
- SLL: reset, then start with Shift_In=0x3333, Shift_Val=4, Mode=00 → done pulses in cycle 6, Shift_Out=0x3330, busy high in cycles 1–6.
- SRA: Shift_In=0x8001, Shift_Val=15, Mode=01 → done in cycle 17, Shift_Out=0xFFFF. Repeat with Shift_In=0x7FFE → Shift_Out=0x0000.
- Rotate round trip: ROR 0x3333 by 5 → 0x9999. Then ROL 0x9999 by 5 → 0x3333. Sweep Shift_Val 0–15 for Shift_In 0x3333..0x3396 in all four modes and compare against the expressions above.
- Zero shift: Shift_Val=0, Mode=10, Shift_In=0xA5C3 → done in cycle 2, Shift_Out=0xA5C3.
- Start while busy: assert start with different operands in every cycle of a Shift_Val=3 SLL on 0x0001 → result 0x0008, and exactly one done pulse per accepted start. The second operation starts only from IDLE.
- Reset mid-operation: drop rst_n for one edge during the SHIFT state of a Shift_Val=10 op → busy=0, done=0 and Shift_Out=0 on the next cycle, with no later done. A fresh start then completes normally.
